// File: rtl/axi2rib_bridge.sv
// AXI4-Lite slave that turns single AXI transactions into RIB master accesses.
// Optional read-modify-write for partial strobes is enabled by defining AXI2RIB_RMW_EN.
module axi2rib_bridge #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic        rib_req_o,
    output logic        rib_we_o,
    output logic [31:0] rib_addr_o,
    output logic [31:0] rib_data_o,
    input  logic [31:0] rib_data_i,
    input  logic        rib_gnt_i
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_RESP = 3'd2;
`ifdef AXI2RIB_RMW_EN
    localparam logic [2:0] ST_RMW_RD  = 3'd3;
`endif
    localparam logic [2:0] ST_WR_REQ  = 3'd4;
    localparam logic [2:0] ST_WR_RESP = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_last_q, rr_last_d;   // 1: last serviced transaction was a read
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [1:0]       bresp_q, bresp_d;

    logic rd_pend, wr_pend, sel_rd, at_limit, in_req;

    // Word alignment discards the byte offset of incoming addresses.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign rd_pend  = s_arvalid;
    assign wr_pend  = s_awvalid && s_wvalid;
    assign sel_rd   = rd_pend && (!wr_pend || !rr_last_q);
    assign at_limit = (cnt_q == CNT_LAST);

`ifdef AXI2RIB_RMW_EN
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] merged;

    // Strobed bytes come from the AXI write data, the rest from the word just read.
    always_comb begin
        merged = rib_data_i;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end
`endif

    always_comb begin
        in_req = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
`ifdef AXI2RIB_RMW_EN
        if (state_q == ST_RMW_RD) begin
            in_req = 1'b1;
        end
`endif
    end

    assign rib_req_o  = in_req;
    assign rib_we_o   = (state_q == ST_WR_REQ);
    assign rib_addr_o = in_req ? addr_q : 32'h0;
    assign rib_data_o = (state_q == ST_WR_REQ) ? wdata_q : 32'h0;

    assign s_rvalid = (state_q == ST_RD_RESP);
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;
    assign s_bvalid = (state_q == ST_WR_RESP);
    assign s_bresp  = bresp_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        bresp_d   = bresp_q;
`ifdef AXI2RIB_RMW_EN
        wstrb_d   = wstrb_q;
`endif
        s_arready = 1'b0;
        s_awready = 1'b0;
        s_wready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_rd) begin
                    s_arready = 1'b1;
                    addr_d    = {s_araddr[31:2], 2'b00};
                    rr_last_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_RD_REQ;
                end else if (wr_pend) begin
                    s_awready = 1'b1;
                    s_wready  = 1'b1;
                    addr_d    = {s_awaddr[31:2], 2'b00};
                    wdata_d   = s_wdata;
                    rr_last_d = 1'b0;
                    cnt_d     = '0;
`ifdef AXI2RIB_RMW_EN
                    wstrb_d   = s_wstrb;
`endif
                    if (s_wstrb == 4'hF) begin
                        state_d = ST_WR_REQ;
                    end else if (s_wstrb == 4'h0) begin
                        bresp_d = RESP_OKAY;
                        state_d = ST_WR_RESP;
                    end else begin
`ifdef AXI2RIB_RMW_EN
                        state_d = ST_RMW_RD;
`else
                        bresp_d = RESP_SLVERR;
                        state_d = ST_WR_RESP;
`endif
                    end
                end
            end
            ST_RD_REQ: begin
                if (rib_gnt_i) begin
                    rdata_d = rib_data_i;
                    rresp_d = RESP_OKAY;
                    state_d = ST_RD_RESP;
                end else if (at_limit) begin
                    rdata_d = 32'h0;
                    rresp_d = RESP_SLVERR;
                    state_d = ST_RD_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef AXI2RIB_RMW_EN
            ST_RMW_RD: begin
                // The write phase gets a fresh timeout window.
                if (rib_gnt_i) begin
                    wdata_d = merged;
                    cnt_d   = '0;
                    state_d = ST_WR_REQ;
                end else if (at_limit) begin
                    bresp_d = RESP_SLVERR;
                    state_d = ST_WR_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_WR_REQ: begin
                if (rib_gnt_i) begin
                    bresp_d = RESP_OKAY;
                    state_d = ST_WR_RESP;
                end else if (at_limit) begin
                    bresp_d = RESP_SLVERR;
                    state_d = ST_WR_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_RESP: begin
                if (s_rready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_RESP: begin
                if (s_bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rr_last_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
`ifdef AXI2RIB_RMW_EN
            wstrb_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            bresp_q   <= bresp_d;
`ifdef AXI2RIB_RMW_EN
            wstrb_q   <= wstrb_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi2rib_bridge.sv
// Bench for axi2rib_bridge: directed vector table, round-robin and reset sequences,
// then random transactions checked against a transaction-level memory model.
module tb_axi2rib_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [3:0]  s_wstrb;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        rib_req_o, rib_we_o, rib_gnt_i;
    logic [31:0] rib_addr_o, rib_data_o, rib_data_i;

    axi2rib_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .rib_req_o(rib_req_o), .rib_we_o(rib_we_o), .rib_addr_o(rib_addr_o),
        .rib_data_o(rib_data_o), .rib_data_i(rib_data_i), .rib_gnt_i(rib_gnt_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RIB slave: grant after gnt_dly waiting cycles when enabled, memory with address-derived contents.
    bit gnt_en = 1'b1;
    int gnt_dly = 0;
    int req_age = 0;
    assign rib_gnt_i = rib_req_o && gnt_en && (req_age >= gnt_dly);
    always @(posedge clk) req_age <= (rib_req_o && !rib_gnt_i) ? req_age + 1 : 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h2000_0004: return 32'hDEAD_BEEF;
            32'h1000_000C: return 32'h1122_3344;
            default:       return a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    logic [31:0] tb_mem [logic [31:0]];
    function automatic logic [31:0] tb_rd(input logic [31:0] a);
        return tb_mem.exists(a) ? tb_mem[a] : init_val(a);
    endfunction

    int req_cycles = 0, wr_cnt = 0, unstable = 0;
    logic [31:0] last_wdata = '0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;

    always @(negedge clk) begin
        if (rib_req_o) begin
            req_cycles++;
            if (rib_addr_o[1:0] != 2'b00) unstable++;
            if (prev_req && !prev_gnt &&
                (rib_addr_o != prev_addr || rib_we_o != prev_we || rib_data_o != prev_data))
                unstable++;
            if (rib_gnt_i && rib_we_o) begin
                wr_cnt++;
                last_wdata = rib_data_o;
                tb_mem[rib_addr_o] = rib_data_o;
            end
        end
        prev_req  = rib_req_o;
        prev_gnt  = rib_gnt_i;
        prev_we   = rib_we_o;
        prev_addr = rib_addr_o;
        prev_data = rib_data_o;
        rib_data_i = tb_rd(rib_addr_o);
    end

    // Reference model memory for the random phase.
    logic [31:0] mdl_mem [logic [31:0]];
    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
    endfunction

    int hold_viol = 0;
    int aw_w_split = 0;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold,
                            output logic [31:0] d, output logic [1:0] r, output int lat);
        int n;
        s_araddr = a;
        s_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_arready && n < 50) begin n++; @(negedge clk); end
        chk("arready", s_arready, 1);
        @(posedge clk);
        #1 s_arvalid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!s_rvalid && lat < 200);
        chk("rvalid_seen", s_rvalid, 1);
        d = s_rdata;
        r = s_rresp;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!s_rvalid || s_rdata !== d || s_rresp !== r) hold_viol++;
        end
        s_rready = 1'b1;
        @(posedge clk);
        #1 s_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, output logic [1:0] r, output int lat);
        int n;
        s_awaddr = a;
        s_wdata = d;
        s_wstrb = s;
        s_awvalid = 1'b1;
        s_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_awready && n < 50) begin n++; @(negedge clk); end
        chk("awready", s_awready, 1);
        if (s_awready != s_wready) aw_w_split++;
        @(posedge clk);
        #1;
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!s_bvalid && lat < 200);
        chk("bvalid_seen", s_bvalid, 1);
        r = s_bresp;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!s_bvalid || s_bresp !== r) hold_viol++;
        end
        s_bready = 1'b1;
        @(posedge clk);
        #1 s_bready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          gen;
        int          gdly;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_req;
        int          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] rd, old, mask, d, a, aa, exp_rd, exp_wd;
        logic [1:0]  resp, exp_resp;
        logic [3:0]  s;
        int          lat, r0, w0, u0, hv0, exp_req, exp_wr, n, sel, hold;
        bit          is_wr, served_rd;

        vt[0]  = '{1'b0, 32'h2000_0004, 32'h0, 4'h0, 1'b1, 0, 2'b00, 32'hDEAD_BEEF, 1, 0, 32'h0};
        vt[1]  = '{1'b1, 32'h1000_0008, 32'h1234_5678, 4'hF, 1'b1, 5, 2'b00, 32'h0, 6, 1, 32'h1234_5678};
`ifdef AXI2RIB_RMW_EN
        vt[2]  = '{1'b1, 32'h1000_000C, 32'h0000_AB00, 4'b0010, 1'b1, 0, 2'b00, 32'h0, 2, 1, 32'h1122_AB44};
        vt[3]  = '{1'b0, 32'h1000_000C, 32'h0, 4'h0, 1'b1, 0, 2'b00, 32'h1122_AB44, 1, 0, 32'h0};
        vt[11] = '{1'b1, 32'h1000_0014, 32'h7700_0000, 4'b1000, 1'b0, 0, 2'b10, 32'h0, TO, 0, 32'h0};
`else
        vt[2]  = '{1'b1, 32'h1000_000C, 32'h0000_AB00, 4'b0010, 1'b1, 0, 2'b10, 32'h0, 0, 0, 32'h0};
        vt[3]  = '{1'b0, 32'h1000_000C, 32'h0, 4'h0, 1'b1, 0, 2'b00, 32'h1122_3344, 1, 0, 32'h0};
        vt[11] = '{1'b1, 32'h1000_0014, 32'h7700_0000, 4'b1000, 1'b0, 0, 2'b10, 32'h0, 0, 0, 32'h0};
`endif
        vt[4]  = '{1'b0, 32'h2000_0008, 32'h0, 4'h0, 1'b0, 0, 2'b10, 32'h0, TO, 0, 32'h0};
        vt[5]  = '{1'b0, 32'h2000_0004, 32'h0, 4'h0, 1'b1, TO-1, 2'b00, 32'hDEAD_BEEF, TO, 0, 32'h0};
        vt[6]  = '{1'b1, 32'h1000_0008, 32'hFFFF_FFFF, 4'h0, 1'b1, 0, 2'b00, 32'h0, 0, 0, 32'h0};
        vt[7]  = '{1'b0, 32'h1000_0008, 32'h0, 4'h0, 1'b1, 0, 2'b00, 32'h1234_5678, 1, 0, 32'h0};
        vt[8]  = '{1'b1, 32'h1000_0010, 32'hAAAA_5555, 4'hF, 1'b0, 0, 2'b10, 32'h0, TO, 0, 32'h0};
        vt[9]  = '{1'b0, 32'h2000_0006, 32'h0, 4'h0, 1'b1, 0, 2'b00, 32'hDEAD_BEEF, 1, 0, 32'h0};
        vt[10] = '{1'b0, 32'h1000_0010, 32'h0, 4'h0, 1'b1, 0, 2'b00, init_val(32'h1000_0010), 1, 0, 32'h0};

        s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_arvalid = 1'b0; s_rready = 1'b0;
        do_reset();

        @(negedge clk);
        chk("rst_req", rib_req_o, 0);
        chk("rst_we", rib_we_o, 0);
        chk("rst_addr", rib_addr_o, 0);
        chk("rst_data", rib_data_o, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_arready_idle", s_arready, 0);
        @(posedge clk);
        #1;

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            gnt_en = vt[i].gen;
            gnt_dly = vt[i].gdly;
            r0 = req_cycles; w0 = wr_cnt; u0 = unstable;
            if (vt[i].wr) axi_write(vt[i].addr, vt[i].data, vt[i].strb, 0, resp, lat);
            else          axi_read(vt[i].addr, 0, rd, resp, lat);
            chk($sformatf("vec%0d_resp", i), resp, vt[i].exp_resp);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_req + 1);
            chk($sformatf("vec%0d_req_cycles", i), req_cycles - r0, vt[i].exp_req);
            chk($sformatf("vec%0d_rib_writes", i), wr_cnt - w0, vt[i].exp_wr);
            chk($sformatf("vec%0d_rib_stable", i), unstable - u0, 0);
            if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            if (vt[i].exp_wr > 0) chk($sformatf("vec%0d_rib_wdata", i), last_wdata, vt[i].exp_wdata);
        end

        // Reset while a read waits for grant.
        gnt_en = 1'b0;
        s_araddr = 32'h2000_0004;
        s_arvalid = 1'b1;
        @(negedge clk);
        chk("rstmid_arready", s_arready, 1);
        @(posedge clk);
        #1 s_arvalid = 1'b0;
        @(negedge clk);
        chk("rstmid_req_before", rib_req_o, 1);
        rst = 1'b1;
        s_arvalid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_req_after", rib_req_o, 0);
        chk("rstmid_rvalid_after", s_rvalid, 0);
        chk("rstmid_arready_after", s_arready, 1);
        s_arvalid = 1'b0;
        @(posedge clk);
        #1 gnt_en = 1'b1;
        gnt_dly = 0;

        // Round-robin with both channels continuously pending.
        do_reset();
        s_araddr = 32'h4000_0010; s_arvalid = 1'b1;
        s_awaddr = 32'h4000_0000; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_rready = 1'b1; s_bready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!s_arready && !s_awready && n < 20) begin n++; @(negedge clk); end
            served_rd = s_arready;
            chk($sformatf("rr_order%0d_is_read", k), {31'b0, served_rd}, (k == 1) ? 32'd0 : 32'd1);
            chk($sformatf("rr_order%0d_exclusive", k), {31'b0, s_arready & s_awready}, 0);
            @(posedge clk);
            #1;
            if (served_rd) s_arvalid = 1'b0;
            else begin s_awvalid = 1'b0; s_wvalid = 1'b0; end
            n = 0;
            @(negedge clk);
            while (!(s_rvalid || s_bvalid) && n < 20) begin n++; @(negedge clk); end
            @(posedge clk);
            #1;
            if (served_rd) s_arvalid = 1'b1;
            else begin s_awvalid = 1'b1; s_wvalid = 1'b1; end
        end
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_rready = 1'b0; s_bready = 1'b0;
        @(posedge clk);
        #1;

        // Random transactions against the memory model.
        hv0 = hold_viol;
        for (int t = 0; t < 60; t++) begin
            a = 32'h3000_0000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            aa = {a[31:2], 2'b00};
            is_wr = 1'($urandom_range(0, 1));
            gnt_en = ($urandom_range(0, 7) != 0);
            gnt_dly = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            d = $urandom;
            sel = $urandom_range(0, 3);
            s = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            exp_rd = 32'h0; exp_wd = 32'h0; exp_wr = 0;
            if (!is_wr) begin
                if (gnt_en) begin exp_resp = 2'b00; exp_rd = mdl_rd(aa); exp_req = gnt_dly + 1; end
                else        begin exp_resp = 2'b10; exp_req = TO; end
            end else if (s == 4'h0) begin
                exp_resp = 2'b00; exp_req = 0;
            end else if (s == 4'hF) begin
                if (gnt_en) begin
                    exp_resp = 2'b00; exp_req = gnt_dly + 1; exp_wr = 1; exp_wd = d;
                    mdl_mem[aa] = d;
                end else begin
                    exp_resp = 2'b10; exp_req = TO;
                end
            end else begin
`ifdef AXI2RIB_RMW_EN
                if (gnt_en) begin
                    old = mdl_rd(aa);
                    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                    exp_wd = (d & mask) | (old & ~mask);
                    exp_resp = 2'b00; exp_req = 2 * (gnt_dly + 1); exp_wr = 1;
                    mdl_mem[aa] = exp_wd;
                end else begin
                    exp_resp = 2'b10; exp_req = TO;
                end
`else
                exp_resp = 2'b10; exp_req = 0;
`endif
            end
            r0 = req_cycles; w0 = wr_cnt; u0 = unstable;
            if (is_wr) axi_write(a, d, s, hold, resp, lat);
            else       axi_read(a, hold, rd, resp, lat);
            chk($sformatf("rnd%0d_resp", t), resp, exp_resp);
            chk($sformatf("rnd%0d_latency", t), lat, exp_req + 1);
            chk($sformatf("rnd%0d_req_cycles", t), req_cycles - r0, exp_req);
            chk($sformatf("rnd%0d_rib_writes", t), wr_cnt - w0, exp_wr);
            chk($sformatf("rnd%0d_rib_stable", t), unstable - u0, 0);
            if (!is_wr) chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            if (exp_wr > 0) chk($sformatf("rnd%0d_rib_wdata", t), last_wdata, exp_wd);
        end
        chk("resp_hold_stable", hold_viol - hv0, 0);
        chk("aw_w_ready_together", aw_w_split, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
